// File: rtl/sram_sdp_be.sv
// sram_sdp_be: simple-dual-port SRAM with byte enables, 1/2-cycle read latency,
// read-during-write policy, post-reset zero clear and out-of-range address flag.
module sram_sdp_be #(
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 16,
    parameter int ADDR_WIDTH     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int BE_WIDTH       = DATA_WIDTH / 8,
    parameter int READ_LATENCY   = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst_i,
    output logic                  ready_o,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [BE_WIDTH-1:0]   wbe_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  addr_err_o
);
    typedef enum logic {CLEAR, RUN} state_t;
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t state, state_next;
    logic [ADDR_WIDTH-1:0] clr_cnt;
    logic clr_we;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic active, w_ok, r_ok, wr_acc, rd_acc, req_err;
    logic [DATA_WIDTH-1:0] rd_word, s1_data;
    logic s1_valid;

    always_ff @(posedge clk) begin
        if (rst_i) state <= RESET_STATE;
        else state <= state_next;
    end

    always_comb state_next = (state == CLEAR && clr_cnt == LAST) ? RUN : state;

    always_comb clr_we = (state == CLEAR) && !rst_i;

    // ready looks at the next state so it rises on the edge that writes the last word
    always_ff @(posedge clk) begin
        if (rst_i) begin
            clr_cnt    <= '0;
            ready_o    <= 1'b0;
            addr_err_o <= 1'b0;
        end else begin
            if (clr_we) clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
            ready_o    <= state_next == RUN;
            addr_err_o <= req_err;
        end
    end

    assign active  = ready_o && !rst_i;
    assign w_ok    = {1'b0, waddr_i} < DEPTH_W;
    assign r_ok    = {1'b0, raddr_i} < DEPTH_W;
    assign wr_acc  = active && we_i && w_ok;
    assign rd_acc  = active && re_i && r_ok;
    assign req_err = active && ((we_i && !w_ok) || (re_i && !r_ok));

    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_cnt] <= '0;
        else if (wr_acc)
            for (int b = 0; b < BE_WIDTH; b++)
                if (wbe_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end

    // write-first bypass merges the enabled bytes of the concurrent write
    always_comb begin
        rd_word = mem[raddr_i];
        for (int b = 0; b < BE_WIDTH; b++)
            if (RDW_MODE == 1 && wr_acc && waddr_i == raddr_i && wbe_i[b])
                rd_word[8*b +: 8] = wdata_i[8*b +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_acc;
            if (rd_acc) s1_data <= rd_word;
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] s2_data;
            logic s2_valid;
            always_ff @(posedge clk) begin
                if (rst_i) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end
            assign rdata_o  = s2_data;
            assign rvalid_o = s2_valid;
        end else begin : g_lat1
            assign rdata_o  = s1_data;
            assign rvalid_o = s1_valid;
        end
    endgenerate
endmodule

// File: tb/tb_sram_sdp_be.sv
// tb_sram_sdp_be: directed vectors for a default instance (L1, READ_FIRST, 16 words)
// and hand sequences for a DEPTH=12, L2, WRITE_FIRST instance.
module tb_sram_sdp_be;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, ready_a, we_a, re_a, rvalid_a, err_a;
    logic [3:0]  waddr_a, raddr_a, wbe_a;
    logic [31:0] wdata_a, rdata_a;
    logic        rst_b, ready_b, we_b, re_b, rvalid_b, err_b;
    logic [3:0]  waddr_b, raddr_b, wbe_b;
    logic [31:0] wdata_b, rdata_b;

    sram_sdp_be dut_a (
        .clk(clk), .rst_i(rst_a), .ready_o(ready_a),
        .we_i(we_a), .waddr_i(waddr_a), .wdata_i(wdata_a), .wbe_i(wbe_a),
        .re_i(re_a), .raddr_i(raddr_a), .rdata_o(rdata_a), .rvalid_o(rvalid_a),
        .addr_err_o(err_a)
    );

    sram_sdp_be #(.DEPTH(12), .READ_LATENCY(2), .RDW_MODE(1)) dut_b (
        .clk(clk), .rst_i(rst_b), .ready_o(ready_b),
        .we_i(we_b), .waddr_i(waddr_b), .wdata_i(wdata_b), .wbe_i(wbe_b),
        .re_i(re_b), .raddr_i(raddr_b), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
        .addr_err_o(err_b)
    );

    typedef struct packed {
        logic        we;
        logic [3:0]  waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        logic        re;
        logic [3:0]  raddr;
        logic        ev;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t vt [32];
    int nv = 0;
    int checks = 0;
    int fails = 0;

    task automatic add(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic re, input logic [3:0] ra,
                       input logic ev, input logic [31:0] ed, input logic ee);
        vt[nv] = '{we, wa, wd, be, re, ra, ev, ed, ee};
        nv++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic edge_t();
        @(posedge clk);
        #1;
    endtask

    task automatic b_drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                           input logic [3:0] be, input logic re, input logic [3:0] ra);
        we_b = we; waddr_b = wa; wdata_b = wd; wbe_b = be; re_b = re; raddr_b = ra;
    endtask

    initial begin
        int na, nb, spur;
        we_a = 0; waddr_a = 0; wdata_a = 0; wbe_a = 0; re_a = 0; raddr_a = 0;
        b_drive(0, 0, 0, 0, 0, 0);
        rst_a = 1; rst_b = 1;
        edge_t();
        chk("a_reset_ready", ready_a, 0);
        chk("a_reset_rvalid", rvalid_a, 0);
        chk("a_reset_rdata", rdata_a, 0);
        chk("a_reset_err", err_a, 0);
        chk("b_reset_ready", ready_b, 0);
        chk("b_reset_rvalid", rvalid_b, 0);
        rst_a = 0; rst_b = 0;
        repeat (5) edge_t();
        rst_a = 1; rst_b = 1;
        edge_t();
        rst_a = 0; rst_b = 0;
        na = 0; nb = 0;
        for (int n = 1; n <= 40; n++) begin
            edge_t();
            if (na == 0 && ready_a) na = n;
            if (nb == 0 && ready_b) nb = n;
            if (na != 0 && nb != 0) break;
        end
        chk("a_clear_cycles", na, 16);
        chk("b_clear_cycles", nb, 12);

        for (int i = 0; i < 16; i++) add(0, 0, 0, 0, 1, 4'(i), 1, 32'h0, 0);
        add(1, 3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 0);
        add(1, 3, 32'h11223344, 4'h5, 0, 0, 0, 32'h0, 0);
        add(0, 0, 0, 0, 1, 3, 1, 32'hDE22BE44, 0);
        add(0, 0, 0, 0, 0, 0, 0, 32'hDE22BE44, 0);
        add(1, 5, 32'hAAAA5555, 4'hF, 1, 5, 1, 32'h0, 0);
        add(0, 0, 0, 0, 1, 5, 1, 32'hAAAA5555, 0);
        add(1, 5, 32'h12345678, 4'h0, 0, 0, 0, 32'hAAAA5555, 0);
        add(0, 0, 0, 0, 1, 5, 1, 32'hAAAA5555, 0);
        add(1, 15, 32'hFFFFFFFF, 4'h8, 0, 0, 0, 32'hAAAA5555, 0);
        add(1, 7, 32'h01020304, 4'hF, 1, 3, 1, 32'hDE22BE44, 0);
        add(0, 0, 0, 0, 1, 15, 1, 32'hFF000000, 0);
        add(0, 0, 0, 0, 1, 7, 1, 32'h01020304, 0);
        for (int i = 0; i < nv; i++) begin
            we_a = vt[i].we; waddr_a = vt[i].waddr; wdata_a = vt[i].wdata;
            wbe_a = vt[i].wbe; re_a = vt[i].re; raddr_a = vt[i].raddr;
            edge_t();
            chk($sformatf("a_vec%0d_rvalid", i), rvalid_a, vt[i].ev);
            chk($sformatf("a_vec%0d_rdata", i), rdata_a, vt[i].ed);
            chk($sformatf("a_vec%0d_err", i), err_a, vt[i].ee);
        end
        we_a = 0; re_a = 0;

        b_drive(1, 5, 32'hAAAA5555, 4'hF, 1, 5);
        edge_t();
        chk("b_rdw_early", rvalid_b, 0);
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_rdw_rvalid", rvalid_b, 1);
        chk("b_rdw_rdata", rdata_b, 32'hAAAA5555);
        edge_t();
        chk("b_rdw_pulse", rvalid_b, 0);

        for (int i = 0; i < 8; i++) begin
            b_drive(1, 4'(i), 32'h100 + i, 4'hF, 0, 0);
            edge_t();
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) b_drive(0, 0, 0, 0, 1, 4'(i));
            else b_drive(0, 0, 0, 0, 0, 0);
            edge_t();
            chk($sformatf("b_burst%0d_rvalid", i), rvalid_b, (i >= 1 && i <= 8) ? 1 : 0);
            if (i >= 1) chk($sformatf("b_burst%0d_rdata", i), rdata_b, 32'h100 + ((i > 8) ? 8 : i) - 1);
        end

        b_drive(1, 13, 32'hFFFFFFFF, 4'hF, 1, 14);
        edge_t();
        chk("b_oor_err", err_b, 1);
        chk("b_oor_rvalid0", rvalid_b, 0);
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_oor_err_single", err_b, 0);
        chk("b_oor_rvalid1", rvalid_b, 0);
        edge_t();
        chk("b_oor_rvalid2", rvalid_b, 0);
        b_drive(0, 0, 0, 0, 1, 1);
        edge_t();
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_alias_rvalid", rvalid_b, 1);
        chk("b_alias_rdata", rdata_b, 32'h101);
        b_drive(1, 12, 32'hDEADBEEF, 4'hF, 1, 2);
        edge_t();
        chk("b_mixed_err", err_b, 1);
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_mixed_err_off", err_b, 0);
        chk("b_mixed_rvalid", rvalid_b, 1);
        chk("b_mixed_rdata", rdata_b, 32'h102);
        b_drive(1, 11, 32'h000000BB, 4'hF, 0, 0);
        edge_t();
        chk("b_last_addr_err", err_b, 0);
        b_drive(0, 0, 0, 0, 1, 11);
        edge_t();
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_last_addr_rvalid", rvalid_b, 1);
        chk("b_last_addr_rdata", rdata_b, 32'hBB);

        b_drive(0, 0, 0, 0, 1, 3);
        edge_t();
        b_drive(0, 0, 0, 0, 0, 0);
        rst_b = 1;
        edge_t();
        chk("b_rst_rvalid", rvalid_b, 0);
        chk("b_rst_rdata", rdata_b, 0);
        chk("b_rst_ready", ready_b, 0);
        rst_b = 0;
        nb = 0; spur = 0;
        for (int n = 1; n <= 40; n++) begin
            edge_t();
            if (rvalid_b) spur++;
            if (ready_b) begin
                nb = n;
                break;
            end
        end
        chk("b_rst_no_rvalid", spur, 0);
        chk("b_reclear_cycles", nb, 12);
        b_drive(0, 0, 0, 0, 1, 3);
        edge_t();
        b_drive(0, 0, 0, 0, 0, 0);
        edge_t();
        chk("b_cleared_rvalid", rvalid_b, 1);
        chk("b_cleared_rdata", rdata_b, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
